// File: rtl/mux_rr_reg.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_reg
// Brief    : N-channel registered mux with valid/ready handshakes, manual and
//            round-robin selection. Optional MUX_RR_COUNT_EN adds xfer_count.
// Revision : 1.0
// ============================================================================
module mux_rr_reg #(
    parameter int WIDTH    = 3,
    parameter int CHANNELS = 8,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          select,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef MUX_RR_COUNT_EN
    ,
    output logic [15:0]               xfer_count
`endif
);

    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    grant_idx;
    logic [WIDTH-1:0]    grant_data;
    logic                load;
    logic                xfer;

    logic [WIDTH-1:0]    out_data_q,  out_data_d;
    logic [SEL_W-1:0]    out_chan_q,  out_chan_d;
    logic                out_valid_q, out_valid_d;
    logic [SEL_W-1:0]    ptr_q,       ptr_d;

    always_comb begin : grant_logic
        int j;
        grant     = '0;
        grant_idx = '0;
        j         = 0;
        if (!mode) begin
            if (int'(select) < CHANNELS) begin
                grant[select] = in_valid[select];
                grant_idx     = select;
            end
        end else begin
            // Walk downwards so the lowest offset from ptr wins the last write.
            for (int k = CHANNELS - 1; k >= 0; k--) begin
                j = int'(ptr_q) + k;
                if (j >= CHANNELS) begin
                    j = j - CHANNELS;
                end
                if (in_valid[j]) begin
                    grant     = '0;
                    grant[j]  = 1'b1;
                    grant_idx = SEL_W'(j);
                end
            end
        end
    end

    always_comb begin : data_mux
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign load     = !out_valid_q || out_ready;
    assign xfer     = (|grant) && load;
    assign in_ready = (reset_n && load) ? grant : '0;

    always_comb begin : next_state
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_data_d  = grant_data;
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
            ptr_d       = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

`ifdef MUX_RR_COUNT_EN
    logic [15:0] xfer_count_q, xfer_count_d;

    always_comb begin
        xfer_count_d = xfer_count_q;
        if (out_valid_q && out_ready && (xfer_count_q != 16'hFFFF)) begin
            xfer_count_d = xfer_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            xfer_count_q <= '0;
        end else begin
            xfer_count_q <= xfer_count_d;
        end
    end

    assign xfer_count = xfer_count_q;
`else
    // Transfer counter not built.
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_rr_reg
// Brief    : Scoreboard bench for mux_rr_reg (default 8 x 3-bit build).
// Revision : 1.0
// ============================================================================
module tb_mux_rr_reg;

    localparam int W  = 3;
    localparam int C  = 8;
    localparam int SW = 3;

    logic            clock;
    logic            reset_n;
    logic [C*W-1:0]  in_data;
    logic [C-1:0]    in_valid;
    logic [C-1:0]    in_ready;
    logic            mode;
    logic [SW-1:0]   select;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_chan;
    logic            out_valid;
    logic            out_ready;
`ifdef MUX_RR_COUNT_EN
    logic [15:0]     xfer_count;
`endif

    mux_rr_reg #(.WIDTH(W), .CHANNELS(C)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .select    (select),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MUX_RR_COUNT_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [SW-1:0] chan;
        logic [W-1:0]  data;
    } exp_t;

    exp_t        sb[$];
    int          seen[$];
    int          n_checks;
    int          n_errors;
    logic        mvalid;
    int          mptr;
    logic [W-1:0] mlast;
    logic [15:0] mcount;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_grant();
        int j;
        if (!mode) begin
            if (int'(select) < C && in_valid[select]) return int'(select);
            return -1;
        end
        for (int k = 0; k < C; k++) begin
            j = (mptr + k) % C;
            if (in_valid[j]) return j;
        end
        return -1;
    endfunction

    // Sample at the falling edge, advance the model, then step past the rising edge.
    task automatic cycle();
        int         g;
        logic       ld;
        logic [C-1:0] exp_rdy;
        exp_t       e;
        @(negedge clock);
        chk("out_valid", {31'd0, out_valid}, {31'd0, mvalid});
        if (mvalid && sb.size() > 0) begin
            chk("out_data", {29'd0, out_data}, {29'd0, sb[0].data});
            chk("out_chan", {29'd0, out_chan}, {29'd0, sb[0].chan});
        end else begin
            chk("out_hold", {29'd0, out_data}, {29'd0, mlast});
        end
        g       = model_grant();
        ld      = !mvalid || out_ready;
        exp_rdy = (g >= 0 && ld) ? (C'(1) << g) : '0;
        chk("in_ready", {24'd0, in_ready}, {24'd0, exp_rdy});
        if (mvalid && out_ready) begin
            if (sb.size() > 0) begin
                seen.push_back(int'(sb[0].chan));
                void'(sb.pop_front());
            end
            if (mcount != 16'hFFFF) mcount = mcount + 16'd1;
            mvalid = 1'b0;
        end
        if (g >= 0 && ld) begin
            e.chan = SW'(g);
            e.data = in_data[g*W +: W];
            sb.push_back(e);
            mvalid = 1'b1;
            mlast  = e.data;
            mptr   = (g + 1) % C;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = '1;
        @(negedge clock);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  {29'd0, out_data},  32'd0);
        chk("rst_out_chan",  {29'd0, out_chan},  32'd0);
        chk("rst_in_ready",  {24'd0, in_ready},  32'd0);
`ifdef MUX_RR_COUNT_EN
        chk("rst_count", {16'd0, xfer_count}, 32'd0);
`endif
        mvalid = 1'b0;
        mptr   = 0;
        mlast  = '0;
        mcount = '0;
        sb.delete();
        seen.delete();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic ident_data();
        for (int i = 0; i < C; i++) in_data[i*W +: W] = W'(i);
    endtask

    task automatic check_seen(input string tag, input int exp_q[$]);
        chk({tag, "_len"}, seen.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < seen.size(); i++) begin
            chk(tag, seen[i], exp_q[i]);
        end
    endtask

    initial begin
        int exp_q[$];
        n_checks  = 0;
        n_errors  = 0;
        reset_n   = 1'b0;
        in_data   = '0;
        in_valid  = '0;
        mode      = 1'b0;
        select    = '0;
        out_ready = 1'b1;
        mvalid    = 1'b0;
        mptr      = 0;
        mlast     = '0;
        mcount    = '0;
        @(posedge clock);
        #1;

        // Manual sweep.
        ident_data();
        do_reset();
        mode = 1'b0;
        for (int s = 0; s < C; s++) begin
            select = SW'(s);
            cycle();
        end
        in_valid = '0;
        cycle();
        exp_q = {0, 1, 2, 3, 4, 5, 6, 7};
        check_seen("sweep_chan", exp_q);

        // Round-robin fairness, all valid.
        do_reset();
        mode = 1'b1;
        repeat (16) cycle();
        in_valid = '0;
        cycle();
        exp_q = {0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6, 7};
        check_seen("rr_chan", exp_q);

        // Round-robin, sparse valid.
        do_reset();
        mode     = 1'b1;
        in_valid = 8'b1000_0101;
        repeat (6) cycle();
        in_valid = '0;
        cycle();
        exp_q = {0, 2, 7, 0, 2, 7};
        check_seen("rr_sparse", exp_q);

        // Back-pressure on channel 3, then round-robin continues from 4.
        do_reset();
        mode   = 1'b0;
        select = 3'd3;
        cycle();
        out_ready = 1'b0;
        repeat (5) cycle();
        chk("bp_data", {29'd0, out_data}, 32'd3);
        chk("bp_rdy",  {24'd0, in_ready}, 32'd0);
        mode      = 1'b1;
        out_ready = 1'b1;
        cycle();
        in_valid = '0;
        cycle();
        exp_q = {3, 4};
        check_seen("bp_chan", exp_q);

        // Manual edge cases: idle selected channel, then drain and hold.
        do_reset();
        mode     = 1'b0;
        in_valid = 8'b1111_0111;
        select   = 3'd3;
        cycle();
        chk("nogrant_valid", {31'd0, out_valid}, 32'd0);
        select = 3'd1;
        cycle();
        in_valid = '0;
        cycle();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_hold",  {29'd0, out_data},  32'd1);
        cycle();

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            in_data   = 24'($urandom);
            in_valid  = 8'($urandom);
            mode      = 1'($urandom);
            select    = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        out_ready = 1'b1;

`ifdef MUX_RR_COUNT_EN
        do_reset();
        mode     = 1'b1;
        in_valid = '1;
        repeat (10) cycle();
        in_valid = '0;
        cycle();
        chk("count_10", {16'd0, xfer_count}, 32'd10);
        chk("count_model", {16'd0, xfer_count}, {16'd0, mcount});
        in_valid = '1;
        repeat (65540) begin
            cycle();
        end
        chk("count_sat", {16'd0, xfer_count}, 32'h0000FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
